// File: rtl/lag_product_acc_pkg.sv
// Shared types and sizing helpers for the lag product accumulator.
package lag_product_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Accumulator width: full-precision product plus headroom for one frame of sums.
  function automatic int unsigned acc_width_f(input int unsigned width, input int unsigned frame);
    return 2 * width + $clog2(frame);
  endfunction

endpackage

// File: rtl/lag_mult.sv
// Signed multiplier for one live/lag sample pair.
// With LAG_PRODUCT_ACC_PIPE_EN defined the product is registered one stage.
module lag_mult #(
  parameter int unsigned width_p = 8
) (
`ifdef LAG_PRODUCT_ACC_PIPE_EN
  input  logic                        clk_i,
  input  logic                        reset_ni,
`endif
  input  logic signed [width_p-1:0]   a_i,
  input  logic signed [width_p-1:0]   b_i,
  output logic signed [2*width_p-1:0] product_o
);

  localparam int unsigned prod_w = 2 * width_p;

  logic signed [prod_w-1:0] product_c;

  assign product_c = prod_w'(a_i) * prod_w'(b_i);

`ifdef LAG_PRODUCT_ACC_PIPE_EN
  // Product pipeline register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      product_o <= '0;
    end else begin
      product_o <= product_c;
    end
  end
`else
  assign product_o = product_c;
`endif

endmodule

// File: rtl/lag_product_acc.sv
// Lag product accumulator: sums live*lag products over a frame of frame_p pairs
// and presents the result until the downstream accepts it.
// Optional macro LAG_PRODUCT_ACC_PIPE_EN adds a product pipeline stage.
module lag_product_acc
  import lag_product_acc_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned frame_p = 64
) (
  input  logic                                              clk_i,
  input  logic                                              reset_ni,
  input  logic signed [width_p-1:0]                         live_data_i,
  input  logic                                              live_valid_i,
  output logic                                              live_ready_o,
  input  logic signed [width_p-1:0]                         lag_data_i,
  input  logic                                              lag_valid_i,
  output logic                                              lag_ready_o,
  output logic                                              valid_o,
  output logic signed [acc_width_f(width_p, frame_p)-1:0]   data_o,
  input  logic                                              ready_i
);

  localparam int unsigned acc_width = acc_width_f(width_p, frame_p);
  localparam int unsigned cnt_w     = $clog2(frame_p);
  localparam int unsigned prod_w    = 2 * width_p;

  state_e                   state;
  logic [cnt_w-1:0]         cnt;
  logic signed [acc_width-1:0] acc;
  logic signed [prod_w-1:0] product;

  logic                     open_c;
  logic                     take_c;
  logic                     last_c;
  logic                     acc_en_c;
  logic                     acc_last_c;
  logic signed [acc_width-1:0] sum_c;

  assign last_c       = (cnt == cnt_w'(frame_p - 1));
  assign take_c       = open_c && live_valid_i && lag_valid_i;
  assign live_ready_o = open_c && lag_valid_i;
  assign lag_ready_o  = open_c && live_valid_i;
  assign sum_c        = acc + acc_width'(product);

  lag_mult #(
    .width_p   (width_p)
  ) u_mult (
`ifdef LAG_PRODUCT_ACC_PIPE_EN
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
`endif
    .a_i       (live_data_i),
    .b_i       (lag_data_i),
    .product_o (product)
  );

`ifdef LAG_PRODUCT_ACC_PIPE_EN
  logic take_q;
  logic last_q;

  // Takes pause while the final product of a frame is still in flight.
  assign open_c     = (state == ACCUM) && !last_q;
  assign acc_en_c   = take_q;
  assign acc_last_c = last_q;

  // Take and last-pair flags travel alongside the registered product.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      take_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      take_q <= take_c;
      last_q <= take_c && last_c;
    end
  end
`else
  assign open_c     = (state == ACCUM);
  assign acc_en_c   = take_c;
  assign acc_last_c = take_c && last_c;
`endif

  // Pair counter, wrapping on the last pair of each frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt <= '0;
    end else if (take_c) begin
      cnt <= last_c ? '0 : cnt + cnt_w'(1);
    end
  end

  // Accumulate / hold state machine with registered result and valid.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= ACCUM;
      acc     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (acc_en_c) begin
            if (acc_last_c) begin
              data_o  <= sum_c;
              acc     <= '0;
              valid_o <= 1'b1;
              state   <= HOLD;
            end else begin
              acc <= sum_c;
            end
          end
        end
        HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= ACCUM;
          end
        end
        default: begin
          state   <= ACCUM;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lag_product_acc.sv
// Self-checking bench for lag_product_acc (width_p=8, frame_p=4).
// Honours LAG_PRODUCT_ACC_PIPE_EN for the expected result latency.
module tb_lag_product_acc;

  localparam int unsigned W  = 8;
  localparam int unsigned F  = 4;
  localparam int unsigned AW = 18;
`ifdef LAG_PRODUCT_ACC_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                 clk;
  logic                 reset_ni;
  logic signed [W-1:0]  live_data;
  logic                 live_valid;
  logic                 live_ready;
  logic signed [W-1:0]  lag_data;
  logic                 lag_valid;
  logic                 lag_ready;
  logic                 valid_o;
  logic signed [AW-1:0] data_o;
  logic                 ready;

  int n_chk  = 0;
  int n_fail = 0;

  lag_product_acc #(
    .width_p      (W),
    .frame_p      (F)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .live_data_i  (live_data),
    .live_valid_i (live_valid),
    .live_ready_o (live_ready),
    .lag_data_i   (lag_data),
    .lag_valid_i  (lag_valid),
    .lag_ready_o  (lag_ready),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .ready_i      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame of products, result presentation after LAT edges.
  int     m_frame[$];
  bit     m_hold = 1'b0;
  int     m_pend = 0;
  longint m_data = 0;
  longint m_res  = 0;
  bit     m_take;

  function automatic bit m_open();
    return !m_hold && (m_pend == 0);
  endfunction

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      m_frame.delete();
      m_hold = 1'b0;
      m_pend = 0;
      m_data = 0;
    end else begin
      m_take = m_open() && live_valid && lag_valid;
      if (m_hold && ready) begin
        m_hold = 1'b0;
      end else if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_hold = 1'b1;
          m_data = m_res;
        end
      end
      if (m_take) begin
        m_frame.push_back(int'(live_data) * int'(lag_data));
        if (m_frame.size() == F) begin
          m_res = 0;
          foreach (m_frame[i]) m_res += m_frame[i];
          m_frame.delete();
          if (LAT == 1) begin
            m_hold = 1'b1;
            m_data = m_res;
          end else begin
            m_pend = LAT - 1;
          end
        end
      end
    end
  end

  task automatic check_outputs();
    check_val("live_ready", longint'(live_ready), longint'(m_open() && lag_valid));
    check_val("lag_ready", longint'(lag_ready), longint'(m_open() && live_valid));
    check_val("valid", longint'(valid_o), longint'(m_hold));
    check_val("data", longint'(data_o), m_data);
  endtask

  // One clock: drive inputs, check against model, advance past the edge.
  task automatic cycle(input bit lv, input logic [W-1:0] ld, input bit gv,
                       input logic [W-1:0] gd, input bit rdy);
    live_valid = lv;
    live_data  = ld;
    lag_valid  = gv;
    lag_data   = gd;
    ready      = rdy;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for valid_o; n counts edges since the final take.
  task automatic wait_valid(input bit rdy, output int n);
    live_valid = 1'b0;
    lag_valid  = 1'b0;
    ready      = rdy;
    n = 1;
    while (!valid_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!valid_o) check_val("valid_timeout", 0, 1);
  endtask

  task automatic pulse_reset();
    live_valid = 1'b1;
    lag_valid  = 1'b1;
    reset_ni   = 1'b0;
    #2;
    check_val("rst_valid", longint'(valid_o), 0);
    check_val("rst_data", longint'(data_o), 0);
    check_val("rst_live_ready", longint'(live_ready), 1);
    check_val("rst_lag_ready", longint'(lag_ready), 1);
    live_valid = 1'b0;
    lag_valid  = 1'b0;
    #1;
    reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int vc;
    reset_ni   = 1'b0;
    live_valid = 1'b0;
    lag_valid  = 1'b0;
    live_data  = '0;
    lag_data   = '0;
    ready      = 1'b0;
    #2;
    check_val("reset_valid", longint'(valid_o), 0);
    check_val("reset_data", longint'(data_o), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_ni = 1'b1;

    // Basic frame 1..4 squared
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b1, W'(i), 1'b1);
    wait_valid(1'b1, n);
    check_val("lat_basic", n, LAT);
    check_val("sum_basic", longint'(data_o), 30);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Extreme operands
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h80, 1'b1, 8'h80, 1'b1);
    wait_valid(1'b1, n);
    check_val("sum_neg_neg", longint'(data_o), 65536);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h80, 1'b1, 8'h7F, 1'b1);
    wait_valid(1'b1, n);
    check_val("sum_neg_pos", longint'(data_o), -65024);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Backpressure: result held for 5 cycles of ready low
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(i + 2), 1'b1, 8'hFD, 1'b0);
    for (int i = 0; i < LAT - 1; i++) cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    vc = 0;
    for (int i = 0; i < 5; i++) begin
      if (valid_o) vc++;
      cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    end
    if (valid_o) vc++;
    check_val("hold_data", longint'(data_o), -42);
    cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    check_val("hold_cycles", vc, 6);
    check_val("hold_release", longint'(valid_o), 0);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // One-sided valid stalls, then the pair is consumed
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd5, 1'b0, '0, 1'b1);
    cycle(1'b1, 8'd5, 1'b1, 8'd6, 1'b1);
    cycle(1'b1, 8'd1, 1'b1, 8'd1, 1'b1);
    cycle(1'b0, '0, 1'b1, 8'd9, 1'b1);
    cycle(1'b1, 8'd2, 1'b1, 8'd2, 1'b1);
    cycle(1'b1, 8'd0, 1'b1, 8'd7, 1'b1);
    wait_valid(1'b1, n);
    check_val("sum_stall", longint'(data_o), 35);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Reset mid-frame discards the partial sum
    cycle(1'b1, 8'd3, 1'b1, 8'd3, 1'b1);
    cycle(1'b1, 8'd3, 1'b1, 8'd3, 1'b1);
    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'd1, 1'b1, 8'd1, 1'b1);
    wait_valid(1'b1, n);
    check_val("sum_after_reset", longint'(data_o), 4);
    cycle(1'b0, '0, 1'b0, '0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) pulse_reset();
      cycle($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 3) != 0,
            W'($urandom), $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
